// File: rtl/axi_master_write_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_master_write_channel: single-burst AXI write master (AW -> W -> B).
// Optional B-response watchdog is compiled in with AXI_MW_TIMEOUT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module axi_master_write_channel #(
  parameter int ADDR_WIDTH          = 32,
  parameter int WRITE_CHANNEL_WIDTH = 32,
  parameter int WRITE_BURST_LEN     = 8,
  parameter int TIMEOUT_CYCLES      = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [WRITE_BURST_LEN-1:0]     req_len,
  input  logic                           src_valid,
  output logic                           src_ready,
  input  logic [WRITE_CHANNEL_WIDTH-1:0] src_data,
  output logic                           done,
  output logic                           done_resp,
  output logic                           timeout_err,
  output logic                           AWVALID,
  input  logic                           AWREADY,
  output logic [ADDR_WIDTH-1:0]          AWADDR,
  output logic [WRITE_BURST_LEN-1:0]     AWLEN,
  output logic [2:0]                     AWSIZE,
  output logic [1:0]                     AWBURST,
  output logic                           WVALID,
  input  logic                           WREADY,
  output logic [WRITE_CHANNEL_WIDTH-1:0] WDATA,
  output logic                           WLAST,
  input  logic                           BVALID,
  input  logic                           BRESP,
  output logic                           BREADY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [WRITE_BURST_LEN-1:0] len_q, len_d;
  // One bit wider than the length so an all-ones length does not wrap early.
  logic [WRITE_BURST_LEN:0]   beat_cnt_q, beat_cnt_d;
  logic                       done_q, done_d;
  logic                       done_resp_q, done_resp_d;
  logic                       last_beat;

  assign last_beat = (beat_cnt_q == {1'b0, len_q});
  assign AWSIZE    = 3'b010;
  assign AWBURST   = 2'b01;
  assign done      = done_q;
  assign done_resp = done_resp_q;

`ifdef AXI_MW_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;

  assign timeout_err = tmo_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_err        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;
    done_resp_d = done_resp_q;
    req_ready   = 1'b0;
    src_ready   = 1'b0;
    AWVALID     = 1'b0;
    AWADDR      = '0;
    AWLEN       = '0;
    WVALID      = 1'b0;
    WDATA       = '0;
    WLAST       = 1'b0;
    BREADY      = 1'b0;
`ifdef AXI_MW_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d     = req_addr;
          len_d      = req_len;
          beat_cnt_d = '0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        AWVALID = 1'b1;
        AWADDR  = addr_q;
        AWLEN   = len_q;
        if (AWREADY) state_d = DATA;
      end
      DATA: begin
        // Source beats pass straight through; a source bubble is a W bubble.
        WVALID    = src_valid;
        WDATA     = src_data;
        WLAST     = src_valid && last_beat;
        src_ready = WREADY;
        if (src_valid && WREADY) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            state_d = RESP;
`ifdef AXI_MW_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end
        end
      end
      RESP: begin
        BREADY = 1'b1;
        if (BVALID) begin
          done_d      = 1'b1;
          done_resp_d = BRESP;
          state_d     = IDLE;
        end
`ifdef AXI_MW_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          done_d      = 1'b1;
          done_resp_d = 1'b0;
          tmo_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      done_q      <= 1'b0;
      done_resp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      done_q      <= done_d;
      done_resp_q <= done_resp_d;
    end
  end

`ifdef AXI_MW_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_master_write_channel.sv
`default_nettype none
// tb_axi_master_write_channel: randomized self-checking bench; a protocol-level
// slave/source model records each burst and the tests compare it to expectations.
module tb_axi_master_write_channel;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 8;
  localparam int TMO = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          src_valid, src_ready;
  logic [DW-1:0] src_data;
  logic          done, done_resp, timeout_err;
  logic          AWVALID, AWREADY;
  logic [AW-1:0] AWADDR;
  logic [LW-1:0] AWLEN;
  logic [2:0]    AWSIZE;
  logic [1:0]    AWBURST;
  logic          WVALID, WREADY;
  logic [DW-1:0] WDATA;
  logic          WLAST;
  logic          BVALID, BRESP, BREADY;

  always #5 clk = ~clk;

  axi_master_write_channel #(
    .ADDR_WIDTH(AW), .WRITE_CHANNEL_WIDTH(DW), .WRITE_BURST_LEN(LW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .done(done), .done_resp(done_resp), .timeout_err(timeout_err),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY)
  );

  int checks = 0;
  int errors = 0;

  // Observations of the most recent burst
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_data[$];
  bit            obs_last[$];
  logic [AW-1:0] aw_addr_obs;
  logic [LW-1:0] aw_len_obs;
  int aw_cnt, aw_unstable, w_early, w_nosrc, srcrdy_bad, busy_ready, b_early, early_done;
  int accept_cyc, b_hs_cyc, done_cyc, bready_first, bready_cycles;
  int tmo_total = 0;
  bit done_seen, done_resp_obs, tmo_seen, hung;

  function automatic int data_mism();
    int m = 0;
    if (obs_data.size() != exp_q.size()) m++;
    for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++)
      if (obs_data[i] !== exp_q[i]) m++;
    return m;
  endfunction

  function automatic int last_pos();
    for (int i = 0; i < obs_last.size(); i++)
      if (obs_last[i]) return i;
    return -1;
  endfunction

  function automatic int n_last();
    int n = 0;
    foreach (obs_last[i]) n += int'(obs_last[i]);
    return n;
  endfunction

  // Plays requester, data source and AXI slave for one burst; records what the DUT did.
  // src_mode: 0 always valid, 1 toggling 1,0,1,0..., 2 random.
  task automatic drive_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                             input int src_mode, input int wr_pct, input int aw_delay,
                             input int b_delay, input bit bresp, input bit b_noise);
    int idx, b_cnt, k;
    bit accepted, aw_done, w_done, aw_hs, w_last_hs, tog;
    exp_q.delete(); obs_data.delete(); obs_last.delete();
    aw_cnt = 0; aw_unstable = 0; w_early = 0; w_nosrc = 0; srcrdy_bad = 0;
    busy_ready = 0; b_early = 0; early_done = 0;
    accept_cyc = -1; b_hs_cyc = -1; done_cyc = -1; bready_first = -1; bready_cycles = 0;
    done_seen = 0; done_resp_obs = 0; tmo_seen = 0; hung = 0;
    aw_addr_obs = '0; aw_len_obs = '0;
    for (int i = 0; i <= int'(len); i++) exp_q.push_back($urandom);
    idx = 0; b_cnt = 0; k = 0; accepted = 0; aw_done = 0; w_done = 0; tog = 1'b1;
    while (!done_seen && k < 5000) begin
      @(negedge clk);
      if (!accepted) begin
        req_valid = 1'b1; req_addr = addr; req_len = len;
      end else if (aw_done && !w_done) begin
        req_valid = 1'($urandom_range(0, 1)); req_addr = $urandom; req_len = LW'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      AWREADY = AWVALID && (aw_cnt >= aw_delay);
      case (src_mode)
        0:       src_valid = 1'b1;
        1:       src_valid = tog;
        default: src_valid = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      src_data = (idx < exp_q.size()) ? exp_q[idx] : $urandom;
      WREADY = (wr_pct >= 100) ? 1'b1 : (int'($urandom_range(1, 100)) <= wr_pct);
      if (BREADY) begin
        BVALID = (b_cnt >= b_delay); BRESP = bresp;
      end else begin
        BVALID = b_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        BRESP  = 1'($urandom_range(0, 1));
      end
      #1;
      aw_hs = 1'b0; w_last_hs = 1'b0;
      if (timeout_err) begin tmo_seen = 1'b1; tmo_total++; end
      if (done) begin
        done_seen = 1'b1; done_resp_obs = done_resp; done_cyc = k;
        if (!w_done) early_done++;
      end
      if (!accepted) begin
        if (req_ready) begin accepted = 1'b1; accept_cyc = k; end
      end else if (req_ready && !done) begin
        busy_ready++;
      end
      if (AWVALID) begin
        if (aw_cnt == 0) begin aw_addr_obs = AWADDR; aw_len_obs = AWLEN; end
        else if (AWADDR !== aw_addr_obs || AWLEN !== aw_len_obs) aw_unstable++;
        if (aw_done) aw_unstable++;
        aw_cnt++;
        aw_hs = AWREADY;
      end
      if (WVALID) begin
        if (!aw_done || w_done) w_early++;
        if (!src_valid) w_nosrc++;
        if (WREADY) begin
          obs_data.push_back(WDATA); obs_last.push_back(WLAST); idx++;
          w_last_hs = WLAST;
        end
      end
      if (aw_done && !w_done) begin
        if (src_ready !== WREADY) srcrdy_bad++;
      end else if (src_ready !== 1'b0) begin
        srcrdy_bad++;
      end
      if (BREADY) begin
        if (!w_done) b_early++;
        if (bready_first < 0) bready_first = k;
        bready_cycles++;
        if (BVALID && b_hs_cyc < 0) b_hs_cyc = k;
        b_cnt++;
      end
      if (aw_hs) aw_done = 1'b1;
      if (w_last_hs) w_done = 1'b1;
      k++;
    end
    hung = !done_seen;
    req_valid = 1'b0; AWREADY = 1'b0; BVALID = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++;
    if ({src_ready, done, done_resp, timeout_err, AWVALID, WVALID, WLAST, BREADY} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl_outputs: got %b expected 00000000",
               {src_ready, done, done_resp, timeout_err, AWVALID, WVALID, WLAST, BREADY});
    end
    checks++;
    if ({AWADDR, AWLEN, WDATA} !== '0) begin
      errors++; $display("FAIL reset_buses: got %h/%h/%h expected 0", AWADDR, AWLEN, WDATA);
    end
    checks++;
    if (AWSIZE !== 3'b010 || AWBURST !== 2'b01) begin
      errors++; $display("FAIL reset_size_burst: got %b/%b expected 010/01", AWSIZE, AWBURST);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_burst();
    drive_burst(32'h100, 8'd3, 0, 100, 0, 0, 1'b1, 1'b0);
    checks++; if (hung) begin errors++; $display("FAIL single_hang: done got 0 expected 1"); end
    checks++; if (aw_addr_obs !== 32'h100) begin errors++; $display("FAIL single_awaddr: got %h expected 100", aw_addr_obs); end
    checks++; if (aw_len_obs !== 8'd3) begin errors++; $display("FAIL single_awlen: got %0d expected 3", aw_len_obs); end
    checks++; if (obs_data.size() != 4) begin errors++; $display("FAIL single_beats: got %0d expected 4", obs_data.size()); end
    checks++; if (data_mism() != 0) begin errors++; $display("FAIL single_data: got %0d mismatches expected 0", data_mism()); end
    checks++; if (last_pos() != 3 || n_last() != 1) begin errors++; $display("FAIL single_wlast: got pos %0d count %0d expected pos 3 count 1", last_pos(), n_last()); end
    checks++; if (done_resp_obs !== 1'b1) begin errors++; $display("FAIL single_done_resp: got %b expected 1", done_resp_obs); end
    checks++; if (srcrdy_bad != 0 || early_done != 0) begin errors++; $display("FAIL single_src_ready: got %0d/%0d bad expected 0/0", srcrdy_bad, early_done); end
  endtask

  task automatic test_aw_stall();
    drive_burst($urandom, 8'd2, 0, 100, 5, 0, 1'b1, 1'b0);
    checks++; if (hung) begin errors++; $display("FAIL stall_hang: done got 0 expected 1"); end
    checks++; if (aw_cnt != 6) begin errors++; $display("FAIL stall_awvalid_cycles: got %0d expected 6", aw_cnt); end
    checks++; if (aw_unstable != 0) begin errors++; $display("FAIL stall_aw_stable: got %0d changes expected 0", aw_unstable); end
    checks++; if (w_early != 0) begin errors++; $display("FAIL stall_w_before_aw: got %0d expected 0", w_early); end
    checks++; if (data_mism() != 0) begin errors++; $display("FAIL stall_data: got %0d mismatches expected 0", data_mism()); end
  endtask

  task automatic test_src_bubbles();
    drive_burst($urandom, 8'd1, 1, 100, 0, 0, 1'b1, 1'b0);
    checks++; if (obs_data.size() != 2) begin errors++; $display("FAIL bubble_beats: got %0d expected 2", obs_data.size()); end
    checks++; if (w_nosrc != 0) begin errors++; $display("FAIL bubble_wvalid_no_src: got %0d expected 0", w_nosrc); end
    checks++; if (last_pos() != 1 || n_last() != 1) begin errors++; $display("FAIL bubble_wlast: got pos %0d count %0d expected pos 1 count 1", last_pos(), n_last()); end
    checks++; if (data_mism() != 0) begin errors++; $display("FAIL bubble_data: got %0d mismatches expected 0", data_mism()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]    lfsr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    bit            resp;
    int            d;
    lfsr = 8'($urandom_range(1, 255));
    for (int it = 0; it < 6; it++) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      d    = int'(lfsr[2:0]);
      addr = $urandom;
      len  = LW'($urandom_range(0, 15));
      resp = 1'($urandom_range(0, 1));
      drive_burst(addr, len, 2, 75, $urandom_range(0, 2), d, resp, 1'b1);
      checks++; if (hung) begin errors++; $display("FAIL b2b_hang[%0d]: done got 0 expected 1", it); end
      checks++; if (accept_cyc != 0) begin errors++; $display("FAIL b2b_accept[%0d]: got cycle %0d expected 0", it, accept_cyc); end
      checks++; if (aw_addr_obs !== addr || aw_len_obs !== len) begin errors++; $display("FAIL b2b_aw[%0d]: got %h/%0d expected %h/%0d", it, aw_addr_obs, aw_len_obs, addr, len); end
      checks++; if (data_mism() != 0) begin errors++; $display("FAIL b2b_data[%0d]: got %0d mismatches expected 0", it, data_mism()); end
      checks++; if (bready_cycles != d + 1) begin errors++; $display("FAIL b2b_bready_held[%0d]: got %0d cycles expected %0d", it, bready_cycles, d + 1); end
      checks++; if (done_cyc != b_hs_cyc + 1) begin errors++; $display("FAIL b2b_done_latency[%0d]: got cycle %0d expected %0d", it, done_cyc, b_hs_cyc + 1); end
      checks++; if (done_resp_obs !== resp) begin errors++; $display("FAIL b2b_done_resp[%0d]: got %b expected %b", it, done_resp_obs, resp); end
      checks++; if (busy_ready != 0) begin errors++; $display("FAIL b2b_req_ready_busy[%0d]: got %0d expected 0", it, busy_ready); end
      checks++; if (b_early != 0 || early_done != 0) begin errors++; $display("FAIL b2b_early_resp[%0d]: got %0d/%0d expected 0/0", it, b_early, early_done); end
    end
  endtask

  task automatic test_max_len();
    drive_burst($urandom, 8'hFF, 2, 70, 1, 2, 1'b1, 1'b1);
    checks++; if (hung) begin errors++; $display("FAIL maxlen_hang: done got 0 expected 1"); end
    checks++; if (obs_data.size() != 256) begin errors++; $display("FAIL maxlen_beats: got %0d expected 256", obs_data.size()); end
    checks++; if (last_pos() != 255 || n_last() != 1) begin errors++; $display("FAIL maxlen_wlast: got pos %0d count %0d expected pos 255 count 1", last_pos(), n_last()); end
    checks++; if (data_mism() != 0) begin errors++; $display("FAIL maxlen_data: got %0d mismatches expected 0", data_mism()); end
    checks++; if (b_early != 0 || early_done != 0) begin errors++; $display("FAIL maxlen_early_resp: got %0d/%0d expected 0/0", b_early, early_done); end
    checks++; if (srcrdy_bad != 0 || w_nosrc != 0) begin errors++; $display("FAIL maxlen_handshake: got %0d/%0d expected 0/0", srcrdy_bad, w_nosrc); end
  endtask

`ifdef AXI_MW_TIMEOUT_EN
  task automatic test_timeout();
    int elapsed;
    drive_burst($urandom, 8'd2, 0, 100, 0, 1000000, 1'b1, 1'b0);
    elapsed = done_cyc - bready_first;
    checks++; if (hung) begin errors++; $display("FAIL timeout_hang: done got 0 expected 1"); end
    checks++; if (!tmo_seen || tmo_total != 1) begin errors++; $display("FAIL timeout_pulse: got %0d pulses expected 1 with done", tmo_total); end
    checks++; if (done_resp_obs !== 1'b0) begin errors++; $display("FAIL timeout_done_resp: got %b expected 0", done_resp_obs); end
    checks++; if (elapsed < TMO || elapsed > TMO + 1) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d..%0d", elapsed, TMO, TMO + 1); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 1'b1 || BREADY !== 1'b0) begin errors++; $display("FAIL timeout_idle: got req_ready %b BREADY %b expected 1/0", req_ready, BREADY); end
  endtask
`else
  task automatic test_no_timeout();
    drive_burst($urandom, 8'd2, 0, 100, 0, 3 * TMO, 1'b1, 1'b0);
    checks++; if (hung) begin errors++; $display("FAIL long_resp_hang: done got 0 expected 1"); end
    checks++; if (bready_cycles != 3 * TMO + 1) begin errors++; $display("FAIL long_resp_wait: got %0d cycles expected %0d", bready_cycles, 3 * TMO + 1); end
    checks++; if (done_resp_obs !== 1'b1) begin errors++; $display("FAIL long_resp_done_resp: got %b expected 1", done_resp_obs); end
    checks++; if (tmo_total != 0) begin errors++; $display("FAIL long_resp_timeout_err: got %0d pulses expected 0", tmo_total); end
  endtask
`endif

  task automatic test_reset_mid_burst();
    bit seen_w;
    int n_done;
    @(negedge clk);
    req_valid = 1'b1; req_addr = $urandom; req_len = 8'd20;
    AWREADY = 1'b1; src_valid = 1'b1; WREADY = 1'b1; BVALID = 1'b0; src_data = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    seen_w = 1'b0;
    for (int i = 0; i < 10 && !seen_w; i++) begin
      @(negedge clk); #1;
      seen_w = WVALID;
    end
    checks++; if (!seen_w) begin errors++; $display("FAIL midrst_data_phase: WVALID got 0 expected 1"); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({AWVALID, WVALID, BREADY, done} !== 4'b0000 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_valids: got AW/W/B/done %b req_ready %b expected 0000/1",
               {AWVALID, WVALID, BREADY, done}, req_ready);
    end
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (done || WVALID) n_done++;
    end
    checks++; if (n_done != 0) begin errors++; $display("FAIL midrst_no_done: got %0d done/W cycles expected 0", n_done); end
    AWREADY = 1'b0; src_valid = 1'b0; WREADY = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
    src_valid = 1'b0; src_data = '0; AWREADY = 1'b0; WREADY = 1'b0;
    BVALID = 1'b0; BRESP = 1'b0;
    test_reset();
    test_single_burst();
    test_aw_stall();
    test_src_bubbles();
    test_back_to_back();
    test_max_len();
`ifdef AXI_MW_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/axi_master_write_channel.md
Name: axi_master_write_channel

Overview:
- AXI-style write master that sits directly upstream of the slave write channel.
- Accepts one burst write request (start address + length) from the core/DMA side, then streams beat data from a local source onto the W channel.
- Issues the AW beat, then W beats with WLAST on the final beat, then waits for the B response.
- Reports completion and response status back to the requester.

Parameters:
- ADDR_WIDTH, 32, address width of AWADDR and req_addr
- WRITE_CHANNEL_WIDTH, 32, data width per beat
- WRITE_BURST_LEN, 8, width of the length field; beats per burst = len + 1
- TIMEOUT_CYCLES, 255, B-response watchdog limit; used only with AXI_MW_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  burst request valid
- req_ready  out  1  master can accept a request
- req_addr  in  ADDR_WIDTH  burst start address
- req_len  in  WRITE_BURST_LEN  beats-1
- src_valid  in  1  source beat data valid
- src_ready  out  1  source beat consumed this cycle
- src_data  in  WRITE_CHANNEL_WIDTH  source beat data
- done  out  1  one-cycle pulse when burst completes
- done_resp  out  1  captured BRESP (1 = OK), valid with done
- timeout_err  out  1  one-cycle pulse on watchdog expiry (0 when feature disabled)
- AWVALID  out  1  write address valid
- AWREADY  in  1  write address ready
- AWADDR  out  ADDR_WIDTH  burst start address
- AWLEN  out  WRITE_BURST_LEN  burst length
- AWSIZE  out  3  constant 3'b010
- AWBURST  out  2  constant 2'b01 (INCR)
- WVALID  out  1  write data valid
- WREADY  in  1  write data ready
- WDATA  out  WRITE_CHANNEL_WIDTH  write data
- WLAST  out  1  last beat of burst
- BVALID  in  1  write response valid
- BRESP  in  1  write response (1 = OK)
- BREADY  out  1  response ready

Behaviour:
- States: IDLE, ADDR, DATA, RESP. Reset → IDLE; all outputs 0 except req_ready=1.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready: latch req_addr into r_addr and req_len into r_len, clear beat_cnt, go to ADDR next cycle.
- ADDR:
  - AWVALID=1; AWADDR=r_addr; AWLEN=r_len. AWVALID stays high and fields stay stable until AWREADY.
  - On AWVALID && AWREADY → DATA.
  - No W beat is driven before the AW handshake completes.
- DATA:
  - WVALID=src_valid; WDATA=src_data (combinational pass-through); src_ready=WREADY.
  - Beat transfer = WVALID && WREADY; beat_cnt increments on each transfer.
  - WLAST = (beat_cnt == r_len) while WVALID.
  - Transfer with WLAST → RESP.
  - src_valid low inserts bubbles; WVALID is never asserted without src_valid.
- RESP:
  - BREADY=1.
  - On BVALID: latch BRESP into done_resp, pulse done for 1 cycle, return to IDLE.
  - The earliest new request accept is the cycle after done.
- Width rules:
  - beat_cnt is WRITE_BURST_LEN+1 bits, so r_len=all-ones (256 beats at default) does not wrap early.
  - r_addr is not incremented by the master; the slave computes beat addresses.
- Simultaneous events:
  - req_valid outside IDLE is ignored (req_ready=0).
  - BVALID arriving while still in DATA is ignored until RESP is entered.
- Reset mid-burst: state returns to IDLE on the next clock; all valids drop; no done pulse; any partial burst is abandoned.
- Latency:
  - req accept → AWVALID: 1 cycle.
  - Last W handshake → BREADY: 1 cycle.
  - BVALID && BREADY → done: same-cycle registered pulse, visible the next cycle.

Optional Feature:
- Macro: AXI_MW_TIMEOUT_EN.
- Enabled:
  - A counter runs in RESP and clears on entry to RESP.
  - If it reaches TIMEOUT_CYCLES without BVALID: pulse timeout_err for 1 cycle, pulse done with done_resp=0, return to IDLE.
- Disabled: no counter; timeout_err tied to 0; RESP waits indefinitely.

Test Plan:
- Single burst, req_addr=0x100, req_len=3, src always valid, slave always ready → AWADDR=0x100 with AWLEN=3; 4 W beats with WLAST on beat 4 only; done=1 with done_resp=1.
- AWREADY held low 5 cycles → AWVALID and AWADDR stable for all 5 cycles; WVALID=0 until after the AW handshake.
- src_valid toggling 1,0,1,0 with req_len=1 → exactly 2 W transfers; WVALID never high without src_valid; WLAST on the 2nd transfer.
- Slave BVALID delayed by random 0–7 cycles (LFSR-style) → BREADY held high; done on the cycle after the BVALID handshake; next req accepted only after done.
- req_len=255 → 256 beats; WLAST only on beat 256; no premature RESP.
- With AXI_MW_TIMEOUT_EN, TIMEOUT_CYCLES=10, BVALID never asserted → timeout_err and done pulse; done_resp=0; state back to IDLE with req_ready=1. Separately, assert rst_n=0 mid-DATA → all valids 0 next cycle; no done pulse.
